// File: rtl/queue_drain_serializer.sv
// Pops words from the byte queue and shifts each one out serially under ready backpressure,
// with a fixed idle gap between frames and a wrapping count of completed frames.
module queue_drain_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  dequeue_out,
  input  logic                  ready_in,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_start,
  output logic                  busy,
  output logic [7:0]            sent_count
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic [7:0]            sent_q, sent_d;
  logic                  deq_q, deq_d;
  logic                  head_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sent_q    <= '0;
      deq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sent_q    <= sent_d;
      deq_q     <= deq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sent_d    = sent_q;
    deq_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (len_in != '0) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          deq_d     = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (ready_in) begin
          shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            sent_d    = sent_q + 8'd1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        // len_in is deliberately ignored here so the queue's pop settles first
        if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign head_bit     = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
  assign serial_valid = (state_q == SHIFT);
  assign serial_out   = serial_valid & head_bit;
  assign frame_start  = serial_valid && (bit_cnt_q == '0);
  assign busy         = (state_q != IDLE);
  assign dequeue_out  = deq_q;
  assign sent_count   = sent_q;

endmodule

// File: tb/tb_queue_drain_serializer.sv
// Bench for queue_drain_serializer: cycle table, directed corner sequences, and a
// queue-level reference model driving random traffic and backpressure.
module tb_queue_drain_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] len_in;
  logic [7:0] data_in;
  logic       ready_in;
  logic       dequeue_out, serial_out, serial_valid, frame_start, busy;
  logic [7:0] sent_count;

  logic [3:0] len_b;
  logic [7:0] data_b;
  logic       ready_b;
  logic       deq_b, sout_b, svld_b, fs_b, busy_b;
  logic [7:0] sent_b;

  always #5 clock = ~clock;

  queue_drain_serializer #(.DATA_WIDTH(8), .LEN_WIDTH(4), .GAP_CYCLES(1), .MSB_FIRST(1)) u_msb (
    .clock(clock), .reset(reset), .len_in(len_in), .data_in(data_in),
    .dequeue_out(dequeue_out), .ready_in(ready_in), .serial_out(serial_out),
    .serial_valid(serial_valid), .frame_start(frame_start), .busy(busy),
    .sent_count(sent_count)
  );

  queue_drain_serializer #(.DATA_WIDTH(8), .LEN_WIDTH(4), .GAP_CYCLES(3), .MSB_FIRST(0)) u_lsb (
    .clock(clock), .reset(reset), .len_in(len_b), .data_in(data_b),
    .dequeue_out(deq_b), .ready_in(ready_b), .serial_out(sout_b),
    .serial_valid(svld_b), .frame_start(fs_b), .busy(busy_b),
    .sent_count(sent_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of words feeding the DUT and the bit stream it must emit.
  logic [7:0] words[$];
  bit         exp_bits[$];
  int         bitpos = 0;
  logic [7:0] exp_sent = 8'd0;
  int         deq_cnt = 0;
  bit         wrap_seen = 1'b0;

  task automatic drive_q();
    len_in  = 4'(words.size());
    data_in = (words.size() != 0) ? words[0] : 8'($urandom);
  endtask

  task automatic run_model(input int ncyc, input bit rnd_ready, input bit enq);
    int gap_run;
    bit seen_valid;
    logic [7:0] w;
    bit eb;
    gap_run = 0;
    seen_valid = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      chk("sent_count", 32'(sent_count), 32'(exp_sent));
      if (dequeue_out) begin
        chk("deq_on_first_bit", 32'({serial_valid, frame_start}), 32'h3);
        if (words.size() == 0) begin
          chk("deq_with_empty_queue", 32'(1), 32'(0));
        end else begin
          w = words.pop_front();
          for (int i = 7; i >= 0; i--) exp_bits.push_back(w[i]);
          deq_cnt++;
        end
      end
      if (serial_valid) begin
        if (!rnd_ready && seen_valid && gap_run != 0) chk("gap_len", 32'(gap_run), 32'(2));
        gap_run = 0;
        seen_valid = 1'b1;
        chk("frame_start", 32'(frame_start), 32'(bitpos == 0));
      end else if (seen_valid) begin
        gap_run++;
      end
      ready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (enq && words.size() < 15 && (!rnd_ready || $urandom_range(0, 5) == 0))
        words.push_back(8'($urandom));
      drive_q();
      if (serial_valid && ready_in) begin
        if (exp_bits.size() == 0) begin
          chk("unexpected_bit", 32'(1), 32'(0));
        end else begin
          eb = exp_bits.pop_front();
          chk("serial_bit", 32'(serial_out), 32'(eb));
        end
        bitpos++;
        if (bitpos == 8) begin
          bitpos = 0;
          if (exp_sent == 8'd255) wrap_seen = 1'b1;
          exp_sent = exp_sent + 8'd1;
        end
      end
    end
  endtask

  typedef struct {
    logic [3:0] len;
    logic [7:0] data;
    logic       rdy;
    logic       deq, vld, sout, fs, bsy;
    logic [7:0] sent;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int vcnt, acc, gapc;
    logic [7:0] got;
    int deq0;

    tbl[0] = '{4'd1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[1] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[2] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[3] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[4] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[5] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[6] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[7] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[8] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[9] = '{4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

    reset = 1'b1;
    len_in = '0; data_in = '0; ready_in = 1'b0;
    len_b = '0; data_b = '0; ready_b = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_outputs", 32'({dequeue_out, serial_valid, serial_out, frame_start, busy}), 32'h0);
    chk("rst_sent", 32'(sent_count), 32'h0);
    reset = 1'b0;

    // Single 0xA5 word, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      len_in = tbl[i].len; data_in = tbl[i].data; ready_in = tbl[i].rdy;
      @(posedge clock); #1;
      chk($sformatf("tbl%0d_deq", i), 32'(dequeue_out), 32'(tbl[i].deq));
      chk($sformatf("tbl%0d_vld", i), 32'(serial_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_out", i), 32'(serial_out), 32'(tbl[i].sout));
      chk($sformatf("tbl%0d_fs", i), 32'(frame_start), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_sent", i), 32'(sent_count), 32'(tbl[i].sent));
    end

    // Backpressure: bit index 3 held for 4 cycles
    @(negedge clock);
    len_in = 4'd1; data_in = 8'hA5; ready_in = 1'b1;
    @(negedge clock);
    len_in = 4'd0;
    vcnt = 0; acc = 0; got = '0;
    for (int c = 0; c < 40; c++) begin
      if (serial_valid) begin
        chk("bp_deq", 32'(dequeue_out), 32'(vcnt == 0));
        ready_in = !(vcnt >= 3 && vcnt <= 6);
        if (!ready_in) chk("bp_hold_bit", 32'(serial_out), 32'(0));
        if (ready_in) begin
          got = {got[6:0], serial_out};
          acc++;
          if (acc == 8) chk("bp_sent_before_last", 32'(sent_count), 32'(1));
        end
        vcnt++;
      end else if (vcnt > 0) begin
        break;
      end
      @(negedge clock);
    end
    chk("bp_valid_cycles", 32'(vcnt), 32'(12));
    chk("bp_bits", 32'(got), 32'hA5);
    chk("bp_sent_after", 32'(sent_count), 32'(2));
    ready_in = 1'b1;

    // Back-to-back drain of three words
    exp_sent = 8'd2;
    words = '{8'h01, 8'h80, 8'hFF};
    drive_q();
    deq0 = deq_cnt;
    run_model(40, 1'b0, 1'b0);
    chk("drain_deq_pulses", 32'(deq_cnt - deq0), 32'(3));
    chk("drain_sent", 32'(sent_count), 32'(5));
    chk("drain_idle", 32'({busy, serial_valid, dequeue_out}), 32'h0);
    chk("drain_bits_left", 32'(exp_bits.size()), 32'(0));

    // Random traffic and backpressure, then a sustained stream through the 255->0 wrap
    run_model(1500, 1'b1, 1'b1);
    run_model(2000, 1'b0, 1'b1);
    run_model(200, 1'b0, 1'b0);
    chk("wrap_seen", 32'(wrap_seen), 32'(1));
    chk("final_sent", 32'(sent_count), 32'(exp_sent));
    chk("final_idle", 32'(busy), 32'(0));

    // Reset mid-frame after 4 bits of 0x3C
    @(negedge clock);
    len_in = 4'd1; data_in = 8'h3C; ready_in = 1'b1;
    @(negedge clock);
    len_in = 4'd0;
    repeat (4) @(negedge clock);
    chk("midrst_busy_before", 32'({busy, serial_valid}), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_outputs", 32'({dequeue_out, serial_valid, serial_out, frame_start, busy}), 32'h0);
    chk("midrst_sent", 32'(sent_count), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("postrst_quiet", 32'({dequeue_out, serial_valid, busy}), 32'h0);
    end

    // LSB-first instance with a 3-cycle gap
    len_b = 4'd1; data_b = 8'h01; ready_b = 1'b1;
    @(negedge clock);
    len_b = 4'd0;
    vcnt = 0; gapc = 0; got = '0;
    for (int c = 0; c < 20; c++) begin
      if (svld_b) begin
        chk("lsb_fs", 32'(fs_b), 32'(vcnt == 0));
        chk("lsb_deq", 32'(deq_b), 32'(vcnt == 0));
        got = {got[6:0], sout_b};
        vcnt++;
      end else if (busy_b) begin
        chk("lsb_gap_out", 32'(sout_b), 32'(0));
        gapc++;
      end
      @(negedge clock);
    end
    chk("lsb_bits", 32'(got), 32'h80);
    chk("lsb_valid_cycles", 32'(vcnt), 32'(8));
    chk("lsb_gap_cycles", 32'(gapc), 32'(3));
    chk("lsb_sent", 32'(sent_b), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
